trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Machine-mode trap controller next to the CSR register file (mstatus/mie/mtvec).
//  Consumes mstatus/mie/mtvec, arbitrates exceptions, interrupts and MRET, and owns mepc/mcause/mip.
//  Drives a PC redirect/flush to fetch and writes mstatus back to the CSR file.
//  Its read port is muxed with the CSR file's csr_rdata.
// PARAMETERS
//  XLEN        32     data/address width
//  SYNC_STAGES 2      irq synchronizer depth (>=2)
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous, active-low reset (asserted at 0)
//  instr_valid      in   1     instruction at pc retires this cycle unless trapped
//  pc               in   XLEN  pc of current instruction
//  ecall            in   1     current instr is ECALL
//  ebreak           in   1     current instr is EBREAK
//  illegal          in   1     current instr is illegal
//  mret             in   1     current instr is MRET
//  irq_ext/irq_timer/irq_sw in 1 each  async level interrupt lines
//  mstatus          in   XLEN  from CSR file (bit3 MIE, bit7 MPIE, bits12:11 MPP)
//  mie              in   XLEN  from CSR file (bit11 MEIE, bit7 MTIE, bit3 MSIE)
//  mtvec            in   XLEN  from CSR file ([1:0] mode, [31:2] base)
//  csr_addr         in   12    CSR address of current instr
//  csr_write_enable in   1     CSR write this cycle
//  csr_wdata        in   XLEN  final write value (after RW/RS/RC)
//  trap_csr_hit     out  1     csr_addr is 0x341/0x342/0x344 (combinational)
//  trap_csr_rdata   out  XLEN  mepc/mcause/mip, 0 when no hit (combinational)
//  redirect_valid   out  1     one-cycle pulse: fetch must load redirect_pc
//  redirect_pc      out  XLEN  trap vector or mepc
//  flush            out  1     kill in-flight instr; equals redirect_valid
//  busy             out  1     high in TRAP/RET state; instr_valid ignored
//  mstatus_wr_en    out  1     CSR file must load mstatus_wr_data into mstatus
//  mstatus_wr_data  out  XLEN  updated mstatus
// BEHAVIOUR
//  Reset: state IDLE; mepc, mcause, sync flops, redirect_valid/pc, flush, busy, mstatus_wr_en/data = 0.
//  mip: synchronized levels {MEIP b11, MTIP b7, MSIP b3}; read-only, writes ignored.
//  Eligible irq: mstatus[3] & mie[k] & mip[k].
//  IDLE with instr_valid, priority high->low:
//   illegal (cause 2) > ebreak (3) > ecall (11) > MEI (0x8000000B) > MSI (0x80000003)
//   > MTI (0x80000007) > mret.
//  Trap taken at edge N: mepc<=pc; mcause<=code.
//   mstatus_wr_en=1 with MPIE<=MIE, MIE<=0, MPP<=2'b11; other bits unchanged.
//   Go to TRAP.
//  TRAP (cycle N+1, exactly 1 cycle): redirect_valid=flush=busy=1; return to IDLE.
//   redirect_pc: mode 0 -> {base,2'b00}.
//   Mode 1 -> base+4*cause[30:0] for interrupts; base for exceptions.
//   Mode >=2 treated as 0.
//  MRET with no higher event: mstatus_wr_en=1 with MIE<=MPIE, MPIE<=1, MPP<=2'b11; go to RET.
//   RET (1 cycle): redirect_pc=mepc, redirect_valid=flush=busy=1.
//  mstatus_wr_en is a 1-cycle pulse in the decision cycle.
//   It has priority over a same-cycle CSR write to mstatus.
//  CSR write to mepc (mepc<=csr_wdata & ~3) or mcause: applied in IDLE.
//   Dropped if a trap is taken in the same cycle (trap wins).
//  instr_valid=0 or busy=1: no event taken; pending irqs stay pending (level).
//  Irq deasserted before eligibility: no trap; no latching of edges.
//  Reset mid-TRAP/RET: immediate IDLE; redirect pulse aborted.
// STRUCTURE
//  Shared package riscv_csr_pkg:
//   CSR addresses 0x300/0x304/0x305/0x341/0x342/0x344
//   cause codes
//   mstatus/mie/mip bit indices
//   trap FSM state encoding IDLE/TRAP/RET
//  Sub-module irq_sync: SYNC_STAGES-deep 3-bit flop synchronizer, rst clears to 0.
// TESTING
//  illegal=1, pc=0x100, mtvec=0x200 ->
//   next cycle redirect 0x200, mepc=0x100, mcause=2, MIE cleared.
//  mstatus[3]=1, mie[7]=1, irq_timer=1, mtvec=0x201 ->
//   after sync+1, redirect 0x21C, mcause=0x80000007.
//  irq_ext & irq_timer both eligible, ecall same cycle ->
//   cause 11 taken; after mret, MEI taken (cause 0x8000000B).
//  mret with mepc=0x104, MPIE=1 ->
//   redirect 0x104 one cycle, mstatus MIE=1, MPIE=1.
//  CSR write mepc=0x303 -> read 0x341 returns 0x300.
//   Same cycle as ecall: mepc=pc, write dropped.
//  rst low during TRAP -> redirect_valid, busy, mepc, mcause all 0 next edge.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR constants shared by the CSR file and the trap controller:
// addresses, cause codes, mstatus/mie/mip bit positions and the trap FSM encoding.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie/mip bit positions
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  // Low five bits of mcause; the interrupt flag is carried separately
  localparam logic [4:0] EXC_ILLEGAL    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
  localparam logic [4:0] EXC_ECALL_M    = 5'd11;
  localparam logic [4:0] INT_CODE_MSI   = 5'd3;
  localparam logic [4:0] INT_CODE_MTI   = 5'd7;
  localparam logic [4:0] INT_CODE_MEI   = 5'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
  localparam logic [1:0] PRIV_M         = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-file side of the trap controller: retiring instruction, CSR access,
// machine CSR inputs, redirect/flush to fetch and mstatus write-back.
interface trap_ctrl_if #(parameter int XLEN = 32);

  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            ecall;
  logic            ebreak;
  logic            illegal;
  logic            mret;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [11:0]     csr_addr;
  logic            csr_write_enable;
  logic [XLEN-1:0] csr_wdata;

  logic            trap_csr_hit;
  logic [XLEN-1:0] trap_csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            busy;
  logic            mstatus_wr_en;
  logic [XLEN-1:0] mstatus_wr_data;

  modport master (
    output instr_valid, pc, ecall, ebreak, illegal, mret,
           mstatus, mie, mtvec, csr_addr, csr_write_enable, csr_wdata,
    input  trap_csr_hit, trap_csr_rdata, redirect_valid, redirect_pc,
           flush, busy, mstatus_wr_en, mstatus_wr_data
  );

  modport slave (
    input  instr_valid, pc, ecall, ebreak, illegal, mret,
           mstatus, mie, mtvec, csr_addr, csr_write_enable, csr_wdata,
    output trap_csr_hit, trap_csr_rdata, redirect_valid, redirect_pc,
           flush, busy, mstatus_wr_en, mstatus_wr_data
  );

endinterface

// File: rtl/irq_sync.sv
// Multi-stage flop synchronizer for the three asynchronous interrupt levels.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] irq_async,
  output logic [2:0] irq_sync
);

  logic [STAGES-1:0][2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_async};
    end
  end

  assign irq_sync = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, interrupts and MRET,
// owns mepc/mcause/mip, and issues a one-cycle redirect plus mstatus write-back.
module trap_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  trap_ctrl_if.slave  bus
);

  localparam logic [XLEN-1:0] MEPC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_e     state;
  logic [2:0]      irq_level;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] irq_eligible;

  logic            take_trap;
  logic            take_ret;
  logic            trap_irq;
  logic [4:0]      trap_code;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mstatus_on_trap;
  logic [XLEN-1:0] mstatus_on_ret;
  logic            csr_wr_mepc;
  logic            csr_wr_mcause;

  irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk       (clk),
    .rst       (rst),
    .irq_async ({irq_ext, irq_timer, irq_sw}),
    .irq_sync  (irq_level)
  );

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mip          = '0;
    mip[IRQ_MEI] = irq_level[2];
    mip[IRQ_MTI] = irq_level[1];
    mip[IRQ_MSI] = irq_level[0];
  end

  assign irq_eligible = mip & bus.mie & {XLEN{bus.mstatus[MSTATUS_MIE]}};

  // Event arbitration; only considered when idle with a retiring instruction
  always_comb begin
    take_trap = 1'b0;
    take_ret  = 1'b0;
    trap_irq  = 1'b0;
    trap_code = '0;
    if (state == ST_IDLE && bus.instr_valid) begin
      take_trap = 1'b1;
      if (bus.illegal) begin
        trap_code = EXC_ILLEGAL;
      end else if (bus.ebreak) begin
        trap_code = EXC_BREAKPOINT;
      end else if (bus.ecall) begin
        trap_code = EXC_ECALL_M;
      end else if (irq_eligible[IRQ_MEI]) begin
        trap_irq  = 1'b1;
        trap_code = INT_CODE_MEI;
      end else if (irq_eligible[IRQ_MSI]) begin
        trap_irq  = 1'b1;
        trap_code = INT_CODE_MSI;
      end else if (irq_eligible[IRQ_MTI]) begin
        trap_irq  = 1'b1;
        trap_code = INT_CODE_MTI;
      end else begin
        take_trap = 1'b0;
        take_ret  = bus.mret;
      end
    end
  end

  assign trap_cause  = {trap_irq, {(XLEN-6){1'b0}}, trap_code};
  assign vec_base    = {bus.mtvec[XLEN-1:2], 2'b00};
  // Vectored mode offsets interrupts only; reserved modes behave as direct
  assign trap_target = (bus.mtvec[1:0] == MTVEC_VECTORED && trap_irq)
                     ? vec_base + XLEN'({trap_code, 2'b00})
                     : vec_base;

  always_comb begin
    mstatus_on_trap                               = bus.mstatus;
    mstatus_on_trap[MSTATUS_MPIE]                 = bus.mstatus[MSTATUS_MIE];
    mstatus_on_trap[MSTATUS_MIE]                  = 1'b0;
    mstatus_on_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;

    mstatus_on_ret                                = bus.mstatus;
    mstatus_on_ret[MSTATUS_MIE]                   = bus.mstatus[MSTATUS_MPIE];
    mstatus_on_ret[MSTATUS_MPIE]                  = 1'b1;
    mstatus_on_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_M;
  end

  // Software writes lose against a trap taken in the same cycle
  assign csr_wr_mepc   = state == ST_IDLE && bus.csr_write_enable && !take_trap
                         && bus.csr_addr == CSR_MEPC;
  assign csr_wr_mcause = state == ST_IDLE && bus.csr_write_enable && !take_trap
                         && bus.csr_addr == CSR_MCAUSE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_IDLE;
      mepc                <= '0;
      mcause              <= '0;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= '0;
      bus.flush           <= 1'b0;
      bus.busy            <= 1'b0;
      bus.mstatus_wr_en   <= 1'b0;
      bus.mstatus_wr_data <= '0;
    end else begin
      bus.redirect_valid <= 1'b0;
      bus.flush          <= 1'b0;
      bus.busy           <= 1'b0;
      bus.mstatus_wr_en  <= 1'b0;

      if (csr_wr_mepc) begin
        mepc <= bus.csr_wdata & MEPC_MASK;
      end
      if (csr_wr_mcause) begin
        mcause <= bus.csr_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (take_trap) begin
            state               <= ST_TRAP;
            mepc                <= bus.pc;
            mcause              <= trap_cause;
            bus.redirect_pc     <= trap_target;
            bus.redirect_valid  <= 1'b1;
            bus.flush           <= 1'b1;
            bus.busy            <= 1'b1;
            bus.mstatus_wr_en   <= 1'b1;
            bus.mstatus_wr_data <= mstatus_on_trap;
          end else if (take_ret) begin
            state               <= ST_RET;
            bus.redirect_pc     <= mepc;
            bus.redirect_valid  <= 1'b1;
            bus.flush           <= 1'b1;
            bus.busy            <= 1'b1;
            bus.mstatus_wr_en   <= 1'b1;
            bus.mstatus_wr_data <= mstatus_on_ret;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.trap_csr_hit   = 1'b0;
    bus.trap_csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MEPC: begin
        bus.trap_csr_hit   = 1'b1;
        bus.trap_csr_rdata = mepc;
      end
      CSR_MCAUSE: begin
        bus.trap_csr_hit   = 1'b1;
        bus.trap_csr_rdata = mcause;
      end
      CSR_MIP: begin
        bus.trap_csr_hit   = 1'b1;
        bus.trap_csr_rdata = mip;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes the expected redirect into a
// queue, a monitor pops and compares on every redirect pulse.
module tb_trap_ctrl;
  import riscv_csr_pkg::*;

  localparam int XLEN = 32;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] mst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq_ext, irq_timer, irq_sw;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .irq_sw    (irq_sw),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // CSR-file model of mstatus: preload from the bench, otherwise follow write-back
  logic        mst_load;
  logic [31:0] mst_load_val;
  logic [31:0] mstatus_q;
  always @(posedge clk) begin
    if (mst_load) mstatus_q <= mst_load_val;
    else if (bus.mstatus_wr_en) mstatus_q <= bus.mstatus_wr_data;
  end
  assign bus.mstatus = mstatus_q;

  // Monitor
  always @(negedge clk) begin
    if (rst && bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc 0x%08h, expected no redirect", bus.redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("redirect_pc", bus.redirect_pc, e.pc);
        check("redirect_mstatus", bus.mstatus_wr_data, e.mst);
        check("redirect_ctrl", {29'd0, bus.flush, bus.busy, bus.mstatus_wr_en}, 32'd7);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_instr();
    bus.instr_valid      = 1'b0;
    bus.ecall            = 1'b0;
    bus.ebreak           = 1'b0;
    bus.illegal          = 1'b0;
    bus.mret             = 1'b0;
    bus.csr_write_enable = 1'b0;
    bus.csr_wdata        = '0;
  endtask

  // One retiring instruction; returns 1 ns into the following cycle
  task automatic do_instr(input logic [31:0] pc, input logic il, input logic eb,
                          input logic ec, input logic mr);
    bus.instr_valid = 1'b1;
    bus.pc          = pc;
    bus.illegal     = il;
    bus.ebreak      = eb;
    bus.ecall       = ec;
    bus.mret        = mr;
    tick();
    clear_instr();
  endtask

  // Instruction that redirects, then step over the TRAP/RET cycle
  task automatic do_trap(input logic [31:0] pc, input logic il, input logic eb,
                         input logic ec, input logic mr);
    do_instr(pc, il, eb, ec, mr);
    tick();
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.instr_valid      = 1'b1;
    bus.csr_addr         = addr;
    bus.csr_write_enable = 1'b1;
    bus.csr_wdata        = data;
    tick();
    clear_instr();
  endtask

  task automatic csr_read(input string name, input logic [11:0] addr, input logic [31:0] want);
    bus.csr_addr = addr;
    #1;
    check(name, bus.trap_csr_rdata, want);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] mst);
    exp_t e;
    e.pc  = pc;
    e.mst = mst;
    exp_q.push_back(e);
  endtask

  initial begin
    int lat;
    int seen;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
    clear_instr();
    bus.pc       = '0;
    bus.csr_addr = '0;
    bus.mie      = '0;
    bus.mtvec    = 32'h0000_0200;
    mst_load     = 1'b1;
    mst_load_val = 32'h0000_0008;

    // Reset state
    tick(); tick();
    check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_mstatus_wr", {31'd0, bus.mstatus_wr_en}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    csr_read("rst_mepc", CSR_MEPC, 32'd0);
    csr_read("rst_mcause", CSR_MCAUSE, 32'd0);
    rst = 1'b1;
    mst_load = 1'b0;
    tick();

    // Illegal instruction, direct vector
    push(32'h200, 32'h1880);
    do_trap(32'h100, 1, 0, 0, 0);
    csr_read("illegal_mepc", CSR_MEPC, 32'h100);
    csr_read("illegal_mcause", CSR_MCAUSE, 32'd2);
    check("illegal_mie_cleared", {31'd0, mstatus_q[MSTATUS_MIE]}, 32'd0);

    // MRET to a software-written mepc
    csr_write(CSR_MEPC, 32'h104);
    csr_read("mepc_write", CSR_MEPC, 32'h104);
    push(32'h104, 32'h1888);
    do_trap(32'h180, 0, 0, 0, 1);

    // CSR writes: mepc alignment, mcause, mip read-only, non-hit address
    csr_write(CSR_MEPC, 32'h303);
    csr_read("mepc_align", CSR_MEPC, 32'h300);
    csr_write(CSR_MCAUSE, 32'h1234);
    csr_read("mcause_write", CSR_MCAUSE, 32'h1234);
    csr_write(CSR_MIP, 32'hFFFF_FFFF);
    csr_read("mip_readonly", CSR_MIP, 32'd0);
    check("mip_hit", {31'd0, bus.trap_csr_hit}, 32'd1);
    csr_read("nohit_rdata", CSR_MSTATUS, 32'd0);
    check("nohit_hit", {31'd0, bus.trap_csr_hit}, 32'd0);

    // ECALL with a same-cycle mepc write: trap wins
    bus.csr_addr         = CSR_MEPC;
    bus.csr_write_enable = 1'b1;
    bus.csr_wdata        = 32'h555;
    push(32'h200, 32'h1880);
    do_trap(32'h400, 0, 0, 1, 0);
    csr_read("ecall_mepc", CSR_MEPC, 32'h400);
    csr_read("ecall_mcause", CSR_MCAUSE, 32'd11);
    push(32'h400, 32'h1888);
    do_trap(32'h404, 0, 0, 0, 1);

    // Timer interrupt, vectored mode; latency is sync depth plus decision cycle
    bus.mtvec = 32'h0000_0201;
    bus.mie   = 32'h80;
    push(32'h21C, 32'h1880);
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h500;
    irq_timer       = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.busy) begin
        lat = i;
        break;
      end
    end
    check("mti_latency", lat, SYNC + 1);
    csr_read("mti_mip", CSR_MIP, 32'h80);
    clear_instr();
    irq_timer = 1'b0;
    tick();
    csr_read("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
    csr_read("mti_mepc", CSR_MEPC, 32'h500);
    push(32'h500, 32'h1888);
    do_trap(32'h504, 0, 0, 0, 1);
    bus.mie = '0;

    // Exception in vectored mode goes to base
    push(32'h200, 32'h1880);
    do_trap(32'h600, 0, 1, 0, 0);
    csr_read("ebreak_mcause", CSR_MCAUSE, 32'd3);
    push(32'h600, 32'h1888);
    do_trap(32'h604, 0, 0, 0, 1);

    // Pending irqs wait for instr_valid; ECALL beats them; MEI beats MTI after MRET
    bus.mie   = 32'h880;
    irq_ext   = 1'b1;
    irq_timer = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy) seen++;
    end
    check("pending_no_valid", seen, 0);
    push(32'h200, 32'h1880);
    do_trap(32'h700, 0, 0, 1, 0);
    csr_read("prio_ecall_mcause", CSR_MCAUSE, 32'd11);
    push(32'h700, 32'h1888);
    do_trap(32'h704, 0, 0, 0, 1);
    push(32'h22C, 32'h1880);
    do_trap(32'h708, 0, 0, 0, 0);
    csr_read("prio_mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_read("prio_mei_mepc", CSR_MEPC, 32'h708);
    irq_ext   = 1'b0;
    irq_timer = 1'b0;
    bus.mie   = '0;
    tick(); tick();
    push(32'h708, 32'h1888);
    do_trap(32'h70C, 0, 0, 0, 1);

    // Short irq pulse gone before an instruction retires: no trap
    bus.mie = 32'h8;
    irq_sw  = 1'b1;
    tick();
    irq_sw = 1'b0;
    tick(); tick(); tick();
    bus.instr_valid = 1'b1;
    bus.pc          = 32'h780;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy) seen++;
    end
    clear_instr();
    check("glitch_no_trap", seen, 0);
    bus.mie = '0;

    // Reset during TRAP aborts the redirect
    bus.mtvec = 32'h0000_0200;
    do_instr(32'h800, 1, 0, 0, 0);
    check("trap_busy", {31'd0, bus.busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_flush", {31'd0, bus.flush}, 32'd0);
    csr_read("abort_mepc", CSR_MEPC, 32'd0);
    csr_read("abort_mcause", CSR_MCAUSE, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Normal operation after reset
    push(32'h200, 32'h1880);
    do_trap(32'h900, 0, 0, 1, 0);
    csr_read("post_rst_mepc", CSR_MEPC, 32'h900);

    tick(); tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
